// File: rtl/dex_hazard_ctl.sv
// Purpose: RAW interlock, redirect squash and HALT drain control in front of the D/EX register.
// Latency: outputs are combinational from the decode slot and the registered scoreboard; state updates on each clk edge.
// Backpressure: a hazard drops fd_en and bubbles D/EX until no producer sits in a hazard slot; HALT freezes the front end.
module dex_hazard_ctl #(
    parameter int DEPTH     = 3,
    parameter int RF_BYPASS = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_valid,
    input  logic             d_rs_used,
    input  logic [2:0]       d_rs,
    input  logic             d_rt_used,
    input  logic [2:0]       d_rt,
    input  logic             d_rd_we,
    input  logic [2:0]       d_rd,
    input  logic             d_halt,
    input  logic             ex_pc_sel,
    output logic             fd_en,
    output logic             fd_flush,
    output logic             dex_bubble,
    output logic             halted,
    output logic             drained,
    output logic [CNT_W-1:0] stall_cnt
);

    // With a write-before-read register file the oldest slot is already visible to decode.
    localparam int HZ_SLOTS = DEPTH - RF_BYPASS;

    logic [DEPTH-1:0] sb_v;
    logic [2:0]       sb_rd [DEPTH];

    logic hit_rs;
    logic hit_rt;
    logic any_v;
    logic flush;
    logic stall;
    logic issue;

    // Scoreboard lookup: match each source against in-flight writers in the hazard window.
    always_comb begin
        hit_rs = 1'b0;
        hit_rt = 1'b0;
        any_v  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < HZ_SLOTS) begin
                if (sb_v[i] && (sb_rd[i] == d_rs)) hit_rs = 1'b1;
                if (sb_v[i] && (sb_rd[i] == d_rt)) hit_rt = 1'b1;
            end
            any_v = any_v | sb_v[i];
        end
    end

    // Issue decision; while reset is held the front end is left free-running and nothing is bubbled.
    always_comb begin
        flush      = rst & ex_pc_sel;
        stall      = rst & d_valid & ~flush & ~halted &
                     ((d_rs_used & hit_rs) | (d_rt_used & hit_rt));
        issue      = rst & d_valid & ~stall & ~flush & ~halted;
        dex_bubble = rst & ~issue;
        fd_en      = ~rst | (~stall & ~halted & ~(issue & d_halt));
        fd_flush   = flush;
        drained    = halted & ~any_v;
    end

    // Shift scoreboard: a new writer enters the EX slot, the oldest one retires.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_v <= '0;
            for (int i = 0; i < DEPTH; i++) sb_rd[i] <= 3'd0;
        end else begin
            sb_v[0]  <= issue & d_rd_we;
            sb_rd[0] <= d_rd;
            for (int i = 1; i < DEPTH; i++) begin
                sb_v[i]  <= sb_v[i-1];
                sb_rd[i] <= sb_rd[i-1];
            end
        end
    end

    // HALT is sticky once it leaves decode; only reset releases the front end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted <= 1'b0;
        end else if (issue && d_halt) begin
            halted <= 1'b1;
        end
    end

    // Saturating count of RAW stall cycles; flushed or empty slots never count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_dex_hazard_ctl.sv
// Purpose: checks dex_hazard_ctl (three parameterisations sharing one stimulus) against a timing-based reference model.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled mid-cycle and just after the edge.
// Backpressure: the model predicts stall/bubble/fd_en from per-register ready times, not from a scoreboard copy.
module tb_dex_hazard_ctl;

    logic       clk;
    logic       rst;
    logic       d_valid, d_rs_used, d_rt_used, d_rd_we, d_halt, ex_pc_sel;
    logic [2:0] d_rs, d_rt, d_rd;

    logic        fd_en0, fd_flush0, bub0, hlt0, drn0;
    logic [15:0] cnt0;
    logic        fd_en1, fd_flush1, bub1, hlt1, drn1;
    logic [15:0] cnt1;
    logic        fd_en2, fd_flush2, bub2, hlt2, drn2;
    logic [7:0]  cnt2;

    dex_hazard_ctl dut (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_rs_used(d_rs_used), .d_rs(d_rs),
        .d_rt_used(d_rt_used), .d_rt(d_rt), .d_rd_we(d_rd_we), .d_rd(d_rd), .d_halt(d_halt),
        .ex_pc_sel(ex_pc_sel), .fd_en(fd_en0), .fd_flush(fd_flush0), .dex_bubble(bub0),
        .halted(hlt0), .drained(drn0), .stall_cnt(cnt0));

    dex_hazard_ctl #(.DEPTH(3), .RF_BYPASS(0), .CNT_W(16)) dut_nb (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_rs_used(d_rs_used), .d_rs(d_rs),
        .d_rt_used(d_rt_used), .d_rt(d_rt), .d_rd_we(d_rd_we), .d_rd(d_rd), .d_halt(d_halt),
        .ex_pc_sel(ex_pc_sel), .fd_en(fd_en1), .fd_flush(fd_flush1), .dex_bubble(bub1),
        .halted(hlt1), .drained(drn1), .stall_cnt(cnt1));

    dex_hazard_ctl #(.DEPTH(3), .RF_BYPASS(1), .CNT_W(8)) dut_sat (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_rs_used(d_rs_used), .d_rs(d_rs),
        .d_rt_used(d_rt_used), .d_rt(d_rt), .d_rd_we(d_rd_we), .d_rd(d_rd), .d_halt(d_halt),
        .ex_pc_sel(ex_pc_sel), .fd_en(fd_en2), .fd_flush(fd_flush2), .dex_bubble(bub2),
        .halted(hlt2), .drained(drn2), .stall_cnt(cnt2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: a write issued in cycle t is readable without stalling from cycle t+H+1,
    // and occupies the pipe through cycle t+3.
    int hz_len [3] = '{2, 3, 2};
    int cnt_max[3] = '{65535, 65535, 255};
    int ready  [3][8];
    int last_exit[3];
    bit m_hlt  [3];
    int m_cnt  [3];
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 8; r++) ready[k][r] = 0;
            last_exit[k] = -1;
            m_hlt[k] = 1'b0;
            m_cnt[k] = 0;
        end
    endtask

    task automatic model_eval(input int k, output bit stall, output bit issue,
                              output bit e_fden, output bit e_bub, output bit e_flush,
                              output bit e_hlt, output bit e_drn, output int e_cnt);
        bit hit_rs, hit_rt;
        hit_rs = ready[k][d_rs] > cyc;
        hit_rt = ready[k][d_rt] > cyc;
        if (!rst) begin
            stall = 0; issue = 0; e_fden = 1; e_bub = 0; e_flush = 0;
            e_hlt = 0; e_drn = 0; e_cnt = 0;
        end else begin
            stall   = d_valid && !ex_pc_sel && !m_hlt[k] &&
                      ((d_rs_used && hit_rs) || (d_rt_used && hit_rt));
            issue   = d_valid && !stall && !ex_pc_sel && !m_hlt[k];
            e_fden  = !stall && !m_hlt[k] && !(issue && d_halt);
            e_bub   = !issue;
            e_flush = ex_pc_sel;
            e_hlt   = m_hlt[k];
            e_drn   = m_hlt[k] && (last_exit[k] < cyc);
            e_cnt   = m_cnt[k];
        end
    endtask

    task automatic model_update();
        bit s, i, a, b, c, d, e;
        int n;
        if (!rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 3; k++) begin
                model_eval(k, s, i, a, b, c, d, e, n);
                if (i && d_rd_we) begin
                    ready[k][d_rd] = cyc + hz_len[k] + 1;
                    last_exit[k]   = cyc + 3;
                end
                if (i && d_halt) m_hlt[k] = 1'b1;
                if (s && m_cnt[k] < cnt_max[k]) m_cnt[k]++;
            end
        end
        cyc++;
    endtask

    task automatic check_all();
        bit s, i, e_fden, e_bub, e_flush, e_hlt, e_drn;
        int e_cnt;
        for (int k = 0; k < 3; k++) begin
            logic o_fden, o_bub, o_flush, o_hlt, o_drn;
            logic [31:0] o_cnt;
            case (k)
                0: begin o_fden = fd_en0; o_bub = bub0; o_flush = fd_flush0; o_hlt = hlt0; o_drn = drn0; o_cnt = {16'd0, cnt0}; end
                1: begin o_fden = fd_en1; o_bub = bub1; o_flush = fd_flush1; o_hlt = hlt1; o_drn = drn1; o_cnt = {16'd0, cnt1}; end
                default: begin o_fden = fd_en2; o_bub = bub2; o_flush = fd_flush2; o_hlt = hlt2; o_drn = drn2; o_cnt = {24'd0, cnt2}; end
            endcase
            model_eval(k, s, i, e_fden, e_bub, e_flush, e_hlt, e_drn, e_cnt);
            chk($sformatf("c%0d_i%0d_fd_en", cyc, k),      {31'd0, o_fden},  {31'd0, e_fden});
            chk($sformatf("c%0d_i%0d_dex_bubble", cyc, k), {31'd0, o_bub},   {31'd0, e_bub});
            chk($sformatf("c%0d_i%0d_fd_flush", cyc, k),   {31'd0, o_flush}, {31'd0, e_flush});
            chk($sformatf("c%0d_i%0d_halted", cyc, k),     {31'd0, o_hlt},   {31'd0, e_hlt});
            chk($sformatf("c%0d_i%0d_drained", cyc, k),    {31'd0, o_drn},   {31'd0, e_drn});
            chk($sformatf("c%0d_i%0d_stall_cnt", cyc, k),  o_cnt,            e_cnt);
        end
    endtask

    task automatic finish_cyc();
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step();
        #4;
        finish_cyc();
    endtask

    task automatic drv(input bit v, input bit rsu, input bit [2:0] rs, input bit rtu,
                       input bit [2:0] rt, input bit we, input bit [2:0] rd,
                       input bit h, input bit pc);
        d_valid = v; d_rs_used = rsu; d_rs = rs; d_rt_used = rtu; d_rt = rt;
        d_rd_we = we; d_rd = rd; d_halt = h; ex_pc_sel = pc;
    endtask

    task automatic drv_rand();
        drv($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1, 3'($urandom_range(7, 0)),
            $urandom_range(1, 0) == 1, 3'($urandom_range(7, 0)), $urandom_range(1, 0) == 1,
            3'($urandom_range(7, 0)), $urandom_range(49, 0) == 0, $urandom_range(7, 0) == 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            drv_rand();
            step();
        end
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;

        // Reset held with random inputs: front end free, nothing bubbled, state cleared.
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            drv_rand();
            #4;
            chk("rst_fd_en", {31'd0, fd_en0}, 32'd1);
            chk("rst_bubble", {31'd0, bub0}, 32'd0);
            chk("rst_halted", {31'd0, hlt0}, 32'd0);
            chk("rst_cnt", {16'd0, cnt0}, 32'd0);
            finish_cyc();
        end
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // Back-to-back dependence on r3.
        do_reset();
        drv(1, 0, 0, 0, 0, 1, 3, 0, 0); step();
        drv(1, 1, 3, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 4; n++) step();
        chk("b2b_cnt_bypass", {16'd0, cnt0}, 32'd2);
        chk("b2b_cnt_nobypass", {16'd0, cnt1}, 32'd3);

        // One independent instruction between producer and consumer.
        do_reset();
        drv(1, 0, 0, 0, 0, 1, 3, 0, 0); step();
        drv(1, 0, 0, 0, 0, 1, 6, 0, 0); step();
        drv(1, 0, 0, 1, 3, 0, 0, 0, 0);
        for (int n = 0; n < 3; n++) step();
        chk("gap1_cnt_bypass", {16'd0, cnt0}, 32'd1);
        chk("gap1_cnt_nobypass", {16'd0, cnt1}, 32'd2);

        // Redirect on top of a stalled reader: flush wins.
        do_reset();
        drv(1, 0, 0, 0, 0, 1, 5, 0, 0); step();
        drv(1, 1, 5, 1, 5, 0, 0, 0, 1);
        #4;
        chk("flush_bubble", {31'd0, bub0}, 32'd1);
        chk("flush_fd_flush", {31'd0, fd_flush0}, 32'd1);
        chk("flush_fd_en", {31'd0, fd_en0}, 32'd1);
        finish_cyc();
        chk("flush_cnt", {16'd0, cnt0}, 32'd0);

        // HALT with two writers in flight, then drain.
        do_reset();
        drv(1, 0, 0, 0, 0, 1, 1, 0, 0); step();
        drv(1, 0, 0, 0, 0, 1, 2, 0, 0); step();
        drv(1, 0, 0, 0, 0, 0, 0, 1, 0); step();
        drv(1, 0, 0, 0, 0, 1, 4, 0, 0);
        chk("halt_halted", {31'd0, hlt0}, 32'd1);
        chk("halt_fd_en", {31'd0, fd_en0}, 32'd0);
        chk("halt_drained_t1", {31'd0, drn0}, 32'd0);
        step();
        chk("halt_drained_t2", {31'd0, drn0}, 32'd0);
        step();
        chk("halt_drained_t3", {31'd0, drn0}, 32'd1);
        step();

        // Non-writing instruction naming r2 never hazards.
        do_reset();
        drv(1, 0, 0, 0, 0, 0, 2, 0, 0); step();
        drv(1, 1, 2, 1, 2, 0, 0, 0, 0);
        #4;
        chk("nowe_fd_en", {31'd0, fd_en0}, 32'd1);
        chk("nowe_bubble", {31'd0, bub0}, 32'd0);
        finish_cyc();

        // Self-dependent chain on r1 keeps stalling: the 8-bit counter saturates, 16-bit keeps going.
        drv(1, 1, 1, 0, 0, 1, 1, 0, 0);
        for (int n = 0; n < 600; n++) step();
        chk("sat_cnt8", {24'd0, cnt2}, 32'd255);
        chk("sat_cnt16_nowrap", {31'd0, (cnt0 > 16'd255)}, 32'd1);

        // Random traffic with occasional asynchronous resets.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(59, 0) != 0);
            drv_rand();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
